dec_ib_src_sched: RTL and testbench

//  Sequencing controller for the decode-side instruction source mux. Decides every cycle whether decode sees
//  the instruction buffer (ib0..ib3) or the FIFO head (bypass). Issues FIFO pops to refill the buffer.

---
 rtl/dec_ib_src_sched.sv | 139 +++++++++++++
 tb/tb_dec_ib_src_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dec_ib_src_sched.sv
// Decode-side instruction source sequencer: buffer vs FIFO-bypass select, FIFO pops, buffer occupancy.
// Optional bypass path (BYP state, 0-cycle FIFO->decode) is enabled by defining DEC_IB_BYPASS_EN.
module dec_ib_src_sched #(
   parameter int IB_DEPTH   = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_CW    = $clog2(FIFO_DEPTH+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FIFO_CW-1:0] fifo_cnt,
   input  logic               dec_i0_decode_d,
   input  logic               dec_i1_decode_d,
   input  logic               flush,
   input  logic               dbg_halt,
   output logic               sel_fifo,
   output logic [1:0]         fifo_pop,
   output logic [1:0]         ib_wr_cnt,
   output logic [3:0]         ib_valid_d,
   output logic [2:0]         ib_occ,
   output logic [1:0]         state
);
   localparam int W = FIFO_CW + 2;
   localparam logic [W-1:0] DEPTH = W'(IB_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, BUF = 2'd1, BYP = 2'd2, FLUSH = 2'd3} state_t;

   state_t       cur_st, nxt_st;
   logic [W-1:0] fifo_w, f2, occ_w, avail, req, cons, space, occ_calc;
   logic [1:0]   pop, wr;

   assign fifo_w = W'(fifo_cnt);
   assign f2     = (fifo_w > W'(2)) ? W'(2) : fifo_w;
   assign occ_w  = W'(ib_occ);

`ifdef DEC_IB_BYPASS_EN
   assign sel_fifo = (cur_st == BYP);
`else
   assign sel_fifo = 1'b0;
`endif

   assign avail = sel_fifo ? f2 : occ_w;
   // i1 only counts when i0 is also taken
   assign req   = W'({dec_i0_decode_d & dec_i1_decode_d, dec_i0_decode_d & ~dec_i1_decode_d});
   assign cons  = dbg_halt ? '0 : ((req < avail) ? req : avail);
   assign space = DEPTH - occ_w + cons;

   always_comb begin
      ib_valid_d = '0;
      for (int k = 0; k < 4; k++)
         ib_valid_d[k] = (cur_st != FLUSH) && (W'(k) < avail);
   end

   always_comb begin
      nxt_st   = cur_st;
      pop      = '0;
      wr       = '0;
      occ_calc = occ_w;
      case (cur_st)
         IDLE, BUF: begin
`ifdef DEC_IB_BYPASS_EN
            // IDLE hands off to BYP with an empty buffer, so it does not refill
            if (cur_st == BUF)
               pop = (f2 < space) ? f2[1:0] : space[1:0];
`else
            pop = (f2 < space) ? f2[1:0] : space[1:0];
`endif
            wr       = pop;
            occ_calc = occ_w - cons + W'(pop);
            if (cur_st == IDLE) begin
               if (fifo_w != '0) begin
`ifdef DEC_IB_BYPASS_EN
                  nxt_st = BYP;
`else
                  nxt_st = BUF;
`endif
               end
            end else if (occ_calc == '0) begin
               if (fifo_w == W'(pop))
                  nxt_st = IDLE;
`ifdef DEC_IB_BYPASS_EN
               else
                  nxt_st = BYP;
`endif
            end
         end
         BYP: begin
            pop      = f2[1:0];
            occ_calc = f2 - cons;
            wr       = occ_calc[1:0];
            if (occ_calc != '0)
               nxt_st = BUF;
            else if (fifo_w != W'(pop))
               nxt_st = BYP;
            else
               nxt_st = IDLE;
         end
         default: begin
            nxt_st   = IDLE;
            occ_calc = '0;
         end
      endcase
      if (dbg_halt) begin
         nxt_st   = cur_st;
         pop      = '0;
         wr       = '0;
         occ_calc = occ_w;
      end
      if (flush) begin
         nxt_st   = FLUSH;
         pop      = '0;
         wr       = '0;
         occ_calc = '0;
      end
      if (rst) begin
         pop = '0;
         wr  = '0;
      end
   end

   assign fifo_pop  = pop;
   assign ib_wr_cnt = wr;
   assign state     = cur_st;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_st <= IDLE;
         ib_occ <= '0;
      end else begin
         cur_st <= nxt_st;
         ib_occ <= occ_calc[2:0];
      end
   end

   a_cons_le_avail: assert property (@(posedge clk) disable iff (rst)
      (!dbg_halt && !flush) |-> (req <= avail));
   // an underflow wraps to a large value, so one bound covers both directions
   a_occ_range: assert property (@(posedge clk) disable iff (rst)
      (occ_w <= DEPTH) && (occ_calc <= DEPTH));
endmodule

// File: tb/tb_dec_ib_src_sched.sv
// Bench for dec_ib_src_sched: directed vector table, reset corner cases, then randomized run vs a behavioural model.
module tb_dec_ib_src_sched;
   localparam int IB_DEPTH   = 4;
   localparam int FIFO_DEPTH = 8;
   localparam int FIFO_CW    = 4;
`ifdef DEC_IB_BYPASS_EN
   localparam bit BYP_EN = 1'b1;
`else
   localparam bit BYP_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic [FIFO_CW-1:0] fifo_cnt;
   logic               i0, i1, flush, dbg_halt;
   logic               sel_fifo;
   logic [1:0]         fifo_pop, ib_wr_cnt, state;
   logic [3:0]         ib_valid_d;
   logic [2:0]         ib_occ;

   int checks = 0;
   int errors = 0;
   int m_st, m_occ;

   always #5 clk = ~clk;

   dec_ib_src_sched #(.IB_DEPTH(IB_DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .FIFO_CW(FIFO_CW)) dut (
      .clk(clk), .rst(rst), .fifo_cnt(fifo_cnt),
      .dec_i0_decode_d(i0), .dec_i1_decode_d(i1),
      .flush(flush), .dbg_halt(dbg_halt),
      .sel_fifo(sel_fifo), .fifo_pop(fifo_pop), .ib_wr_cnt(ib_wr_cnt),
      .ib_valid_d(ib_valid_d), .ib_occ(ib_occ), .state(state)
   );

   typedef struct {
      int fc; bit i0, i1, fl, hl;
      int st, occ, sel, val, pop, wr;
   } vec_t;

   function automatic vec_t mk(int fc, bit a, bit b, bit fl, bit hl,
                               int st, int occ, int sel, int val, int pop, int wr);
      vec_t v;
      v.fc = fc; v.i0 = a; v.i1 = b; v.fl = fl; v.hl = hl;
      v.st = st; v.occ = occ; v.sel = sel; v.val = val; v.pop = pop; v.wr = wr;
      return v;
   endfunction

   function automatic int mn(int a, int b);
      return (a < b) ? a : b;
   endfunction

   // Reference: states 0 idle, 1 buffer, 2 bypass, 3 flush; occupancy as an integer count.
   function automatic void model(input vec_t v, output vec_t e, output int n_st, output int n_occ);
      int want, avail, used;
      e = v;
      e.st  = m_st;
      e.occ = m_occ;
      e.sel = (BYP_EN && m_st == 2) ? 1 : 0;
      avail = (e.sel == 1) ? mn(v.fc, 2) : m_occ;
      want  = v.i0 ? (v.i1 ? 2 : 1) : 0;
      used  = v.hl ? 0 : mn(want, avail);
      e.val = 0;
      if (m_st != 3)
         for (int k = 0; k < avail; k++) e.val += (1 << k);
      e.pop = 0; e.wr = 0;
      n_st  = m_st;
      n_occ = m_occ;
      if (v.fl) begin
         n_st = 3; n_occ = 0;
      end else if (!v.hl) begin
         if (m_st == 3) n_st = 0;
         else if (m_st == 2) begin
            e.pop = mn(v.fc, 2);
            n_occ = e.pop - used;
            e.wr  = n_occ;
            n_st  = (n_occ > 0) ? 1 : ((v.fc - e.pop > 0) ? 2 : 0);
         end else if (m_st == 0 && BYP_EN) begin
            n_st = (v.fc > 0) ? 2 : 0;
         end else begin
            e.pop = mn(mn(v.fc, 2), IB_DEPTH - m_occ + used);
            e.wr  = e.pop;
            n_occ = m_occ - used + e.pop;
            if (m_st == 0) n_st = (v.fc > 0) ? 1 : 0;
            else if (n_occ == 0) n_st = (v.fc - e.pop == 0) ? 0 : (BYP_EN ? 2 : 1);
         end
      end
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input vec_t v);
      chk({tag, ".state"}, int'(state), v.st);
      chk({tag, ".ib_occ"}, int'(ib_occ), v.occ);
      chk({tag, ".sel_fifo"}, int'(sel_fifo), v.sel);
      chk({tag, ".ib_valid_d"}, int'(ib_valid_d), v.val);
      chk({tag, ".fifo_pop"}, int'(fifo_pop), v.pop);
      chk({tag, ".ib_wr_cnt"}, int'(ib_wr_cnt), v.wr);
   endtask

   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      fifo_cnt = FIFO_CW'(v.fc);
      i0 = v.i0; i1 = v.i1; flush = v.fl; dbg_halt = v.hl;
      #1;
      chk_all(tag, v);
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];

   initial begin
      vec_t v, e;
      int ns, no, av, want;

`ifdef DEC_IB_BYPASS_EN
      tbl.push_back(mk(3, 0,0,0,0, 0,0,0,  0,0,0));
      tbl.push_back(mk(3, 0,0,0,0, 2,0,1,  3,2,2));
      tbl.push_back(mk(1, 0,0,0,0, 1,2,0,  3,1,1));
      tbl.push_back(mk(2, 1,0,0,0, 1,3,0,  7,2,2));
      tbl.push_back(mk(0, 1,0,0,0, 1,4,0, 15,0,0));
`else
      tbl.push_back(mk(1, 0,0,0,0, 0,0,0,  0,1,1));
      tbl.push_back(mk(0, 1,0,0,0, 1,1,0,  1,0,0));
      tbl.push_back(mk(5, 0,0,0,0, 0,0,0,  0,2,2));
      tbl.push_back(mk(5, 0,0,0,0, 1,2,0,  3,2,2));
      tbl.push_back(mk(5, 0,0,0,0, 1,4,0, 15,0,0));
      tbl.push_back(mk(5, 1,1,0,0, 1,4,0, 15,2,2));
      tbl.push_back(mk(3, 1,1,0,0, 1,4,0, 15,2,2));
      tbl.push_back(mk(0, 1,1,0,0, 1,4,0, 15,0,0));
      tbl.push_back(mk(0, 1,1,0,0, 1,2,0,  3,0,0));
      tbl.push_back(mk(0, 0,1,0,0, 0,0,0,  0,0,0));
      tbl.push_back(mk(3, 0,0,0,0, 0,0,0,  0,2,2));
      tbl.push_back(mk(4, 1,0,0,0, 1,2,0,  3,2,2));
      tbl.push_back(mk(4, 1,1,0,1, 1,3,0,  7,0,0));
      tbl.push_back(mk(4, 1,1,0,1, 1,3,0,  7,0,0));
      tbl.push_back(mk(0, 1,0,0,0, 1,3,0,  7,0,0));
      tbl.push_back(mk(4, 1,0,1,0, 1,2,0,  3,0,0));
      tbl.push_back(mk(4, 0,0,0,0, 3,0,0,  0,0,0));
      tbl.push_back(mk(4, 0,0,0,0, 0,0,0,  0,2,2));
      tbl.push_back(mk(4, 0,0,1,1, 1,2,0,  3,0,0));
      tbl.push_back(mk(0, 0,0,0,0, 3,0,0,  0,0,0));
      tbl.push_back(mk(2, 0,0,0,0, 0,0,0,  0,2,2));
      tbl.push_back(mk(0, 1,0,0,0, 1,2,0,  3,0,0));
      tbl.push_back(mk(4, 0,0,0,0, 1,1,0,  1,2,2));
`endif

      // reset with a non-empty FIFO: pops must stay suppressed
      rst = 1'b1; fifo_cnt = 4'd3; i0 = 1'b0; i1 = 1'b0; flush = 1'b0; dbg_halt = 1'b0;
      #1;
      chk_all("reset", mk(3, 0,0,0,0, 0,0,0,0,0,0));
      fifo_cnt = '0;
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[n]) apply(tbl[n], $sformatf("vec%0d", n));

      // asynchronous reset mid-cycle from BUF with three entries buffered
      @(negedge clk);
      fifo_cnt = 4'd4; i0 = 1'b1; i1 = 1'b0; flush = 1'b0; dbg_halt = 1'b0;
      #1;
      chk("pre_rst.ib_occ", int'(ib_occ), 3);
      #2 rst = 1'b1;
      #1;
      chk_all("mid_rst", mk(4, 1,0,0,0, 0,0,0,0,0,0));
      @(negedge clk);
      chk_all("held_rst", mk(4, 1,0,0,0, 0,0,0,0,0,0));
      fifo_cnt = '0; i0 = 1'b0;
      rst = 1'b0;
      m_st = 0; m_occ = 0;

      for (int n = 0; n < 800; n++) begin
         v.fc = int'($urandom_range(0, 8));
         av   = (BYP_EN && m_st == 2) ? mn(v.fc, 2) : m_occ;
         want = int'($urandom_range(0, mn(av, 2)));
         v.i0 = (want > 0);
         v.i1 = (want == 2) ? 1'b1 : ((want == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
         v.fl = ($urandom_range(0, 19) == 0);
         v.hl = ($urandom_range(0, 9) == 0);
         model(v, e, ns, no);
         apply(e, $sformatf("rnd%0d", n));
         m_st = ns; m_occ = no;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
